// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encodings and defaults for the memory arbiter
package mem_arbiter_pkg;
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_IF   = 2'd1;
    localparam logic [1:0] ARB_DM   = 2'd2;

    localparam int MAX_LAT_DEFAULT = 15;
endpackage

// File: rtl/arb_timer.sv
// rtl/arb_timer.sv - clear/enable busy-cycle counter with terminal-count output
module arb_timer #(
    parameter int MAX_LAT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(MAX_LAT + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Fires during the busy cycle whose closing edge would bring the count to MAX_LAT.
    assign tc = en && (count_q == CW'(MAX_LAT - 1));
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter for a single-port variable-latency memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_LAT = MAX_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              stall_f,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);
    logic [1:0]        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              drop_q, drop_d;
    logic              timeout_q, timeout_d;
    logic              timer_clr, timer_tc, kill_now;

    arb_timer #(.MAX_LAT(MAX_LAT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .en    (state_q != ARB_IDLE),
        .tc    (timer_tc)
    );

    // A kill in the ack cycle itself still discards the fetch.
    assign kill_now = drop_q | if_kill;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        drop_d      = drop_q;
        timeout_d   = timeout_q;
        timer_clr   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (dm_req && !dm_done_q) begin
                    state_d     = ARB_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    timer_clr   = 1'b1;
                end else if (if_req && !if_kill && !if_done_q) begin
                    state_d     = ARB_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    timer_clr   = 1'b1;
                end
            end
            ARB_IF: begin
                if (mem_ack || timer_tc) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (!mem_ack) timeout_d = 1'b1;
                    if (!kill_now) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_ack ? mem_rdata : '0;
                    end
                end else begin
                    drop_d = kill_now;
                end
            end
            ARB_DM: begin
                if (mem_ack) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    dm_done_d = 1'b1;
                    if (!mem_we_q) dm_rdata_d = mem_rdata;
                end else if (timer_tc) begin
                    state_d    = ARB_IDLE;
                    mem_req_d  = 1'b0;
                    dm_done_d  = 1'b1;
                    dm_rdata_d = '0;
                    timeout_d  = 1'b1;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            drop_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            drop_q      <= drop_d;
            timeout_q   <= timeout_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign if_done     = if_done_q;
    assign dm_done     = dm_done_q;
    assign timeout_err = timeout_q;
    assign stall_f     = if_req & ~if_done_q;
    assign stall_m     = dm_req & ~dm_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_kill, if_done, stall_f;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_done, stall_m;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ack, timeout_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LAT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_kill    (if_kill),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .stall_f    (stall_f),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_done    (dm_done),
        .stall_m    (stall_m),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; if_req = 0; if_addr = 0; if_kill = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        tick(); tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_dm_done", dm_done, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 0;
        tick();

        // 1: fetch only, ack in third busy cycle
        if_req = 1; if_addr = 32'h40; #1;
        chk("t1_stall_f_req", stall_f, 1);
        tick();
        chk("t1_mem_req_c1", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h40);
        chk("t1_mem_we", mem_we, 0);
        tick();
        chk("t1_mem_req_c2", mem_req, 1);
        tick();
        chk("t1_mem_req_c3", mem_req, 1);
        chk("t1_if_done_c3", if_done, 0);
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 0;
        chk("t1_mem_req_done", mem_req, 0);
        chk("t1_if_done", if_done, 1);
        chk("t1_if_rdata", if_rdata, 32'h1234_5678);
        chk("t1_stall_f_done", stall_f, 0);
        if_req = 0;
        tick();
        chk("t1_if_done_after", if_done, 0);

        // 2: simultaneous requests, data port wins
        dm_req = 1; dm_we = 0; dm_addr = 32'h100; if_req = 1; if_addr = 32'h44;
        tick();
        chk("t2_dm_addr", mem_addr, 32'h100);
        chk("t2_mem_req", mem_req, 1);
        chk("t2_stall_f", stall_f, 1);
        chk("t2_stall_m", stall_m, 1);
        mem_ack = 1; mem_rdata = 32'hAAAA_5555;
        tick();
        mem_ack = 0;
        chk("t2_dm_done", dm_done, 1);
        chk("t2_dm_rdata", dm_rdata, 32'hAAAA_5555);
        chk("t2_mem_req_drop", mem_req, 0);
        chk("t2_stall_m_done", stall_m, 0);
        dm_req = 0;
        tick();
        chk("t2_if_grant", mem_req, 1);
        chk("t2_if_addr", mem_addr, 32'h44);
        chk("t2_dm_done_clr", dm_done, 0);
        mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 0;
        chk("t2_if_done", if_done, 1);
        chk("t2_if_rdata", if_rdata, 32'h0BAD_F00D);
        tick();
        chk("t2_no_regrant", mem_req, 0);
        if_req = 0;
        tick();

        // 3: store
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        tick();
        chk("t3_mem_we", mem_we, 1);
        chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t3_mem_addr", mem_addr, 32'h200);
        mem_ack = 1; mem_rdata = 32'h1111_1111;
        tick();
        mem_ack = 0;
        chk("t3_dm_done", dm_done, 1);
        chk("t3_dm_rdata_hold", dm_rdata, 32'hAAAA_5555);
        dm_req = 0; dm_we = 0;
        tick();

        // 4: kill one cycle before ack
        if_req = 1; if_addr = 32'h60;
        tick();
        chk("t4_mem_req", mem_req, 1);
        chk("t4_fetch_we", mem_we, 0);
        chk("t4_fetch_wdata", mem_wdata, 0);
        if_kill = 1;
        tick();
        if_kill = 0;
        mem_ack = 1; mem_rdata = 32'h9999_9999;
        tick();
        mem_ack = 0;
        chk("t4_no_if_done", if_done, 0);
        chk("t4_if_rdata_hold", if_rdata, 32'h0BAD_F00D);
        chk("t4_mem_req_drop", mem_req, 0);
        if_addr = 32'h80;
        tick();
        chk("t4_new_grant", mem_req, 1);
        chk("t4_new_addr", mem_addr, 32'h80);
        mem_ack = 1; mem_rdata = 32'h8080_8080;
        tick();
        mem_ack = 0;
        chk("t4_if_done", if_done, 1);
        chk("t4_if_rdata", if_rdata, 32'h8080_8080);
        if_req = 0;
        tick();

        // 5: watchdog with MAX_LAT=4
        dm_req = 1; dm_we = 0; dm_addr = 32'h300;
        tick();
        chk("t5_busy1", mem_req, 1);
        tick(); tick(); tick();
        chk("t5_busy4", mem_req, 1);
        chk("t5_no_timeout_yet", timeout_err, 0);
        tick();
        chk("t5_mem_req_drop", mem_req, 0);
        chk("t5_timeout", timeout_err, 1);
        chk("t5_dm_done", dm_done, 1);
        chk("t5_dm_rdata_zero", dm_rdata, 0);
        dm_req = 0; mem_ack = 1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 0;
        chk("t5_late_ack_req", mem_req, 0);
        chk("t5_late_ack_done", dm_done, 0);
        chk("t5_late_ack_rdata", dm_rdata, 0);
        tick();
        chk("t5_sticky", timeout_err, 1);

        // 6: reset mid data access
        dm_req = 1; dm_we = 0; dm_addr = 32'h400;
        tick();
        chk("t6_busy", mem_req, 1);
        reset = 1;
        tick();
        chk("t6_mem_req", mem_req, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_timeout_clr", timeout_err, 0);
        chk("t6_dm_done", dm_done, 0);
        chk("t6_if_rdata", if_rdata, 0);
        reset = 0; dm_req = 0; mem_ack = 1; mem_rdata = 32'h7777_7777;
        tick();
        mem_ack = 0;
        chk("t6_stray_req", mem_req, 0);
        chk("t6_stray_done", dm_done, 0);
        tick();
        chk("t6_stray_done2", dm_done, 0);
        chk("t6_stray_rdata", dm_rdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
